// File: rtl/async_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package     : async_fifo_pkg
// Description : Shared pointer-coding helpers and sizing functions for the
//               async FIFO read/write controllers.
// Revision    : 1.0 - initial release
// ============================================================================
package async_fifo_pkg;

  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t width_mask(input int width);
    ptr_word_t m;
    m = '1;
    if (width < PTR_MAX_W) begin
      m = (ptr_word_t'(1) << width) - ptr_word_t'(1);
    end
    return m;
  endfunction

  function automatic ptr_word_t bin2gray(input ptr_word_t bin, input int width);
    ptr_word_t b;
    b = bin & width_mask(width);
    return b ^ (b >> 1);
  endfunction

  // Bits above the pointer width are masked to zero, so the XOR cascade from
  // the top bit down yields the correct binary value for any width.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray, input int width);
    ptr_word_t g;
    ptr_word_t b;
    g = gray & width_mask(width);
    b = '0;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic int align_shift(input int wr_addr_w, input int rd_addr_w);
    return (rd_addr_w > wr_addr_w) ? (rd_addr_w - wr_addr_w) : (wr_addr_w - rd_addr_w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_ptr_sync2.sv
`default_nettype none
// ============================================================================
// Module      : gray_ptr_sync2
// Description : Two-flop synchroniser for a Gray-coded pointer crossing into
//               the local clock domain.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_ptr_sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= D;
      r_sync <= r_meta;
    end
  end

  assign Q = r_sync;

endmodule

`default_nettype wire

// File: rtl/async_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : async_fifo_wr_ctrl
// Description : Write-domain controller for the async FIFO: drives the RAM
//               write port, keeps the write pointers and generates status.
// Revision    : 1.0 - initial release
// ============================================================================
module async_fifo_wr_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDRESS_WRITE_IN  = 5,
  parameter int ADDRESS_WRITE_OUT = 7,
  parameter int DATA_WRITE_IN     = 64,
  parameter int DATA_WRITE_OUT    = 16,
  parameter int AF_LEVEL          = 28
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         WR_REQ,
  input  logic [DATA_WRITE_IN-1:0]     DIN,
  input  logic [ADDRESS_WRITE_OUT:0]   RD_PTR_GRAY,
  output logic                         WR_EN,
  output logic [ADDRESS_WRITE_IN-1:0]  ADDR_WR,
  output logic [DATA_WRITE_IN-1:0]     D,
  output logic [ADDRESS_WRITE_IN:0]    WR_PTR_GRAY,
  output logic                         FULL,
  output logic                         ALMOST_FULL,
  output logic [ADDRESS_WRITE_IN:0]    WR_COUNT,
  output logic                         OVERFLOW
);

  localparam int c_PW    = ADDRESS_WRITE_IN + 1;
  localparam int c_RW    = ADDRESS_WRITE_OUT + 1;
  localparam int c_SHIFT = align_shift(ADDRESS_WRITE_IN, ADDRESS_WRITE_OUT);
  localparam int c_DEPTH_INT = fifo_depth(ADDRESS_WRITE_IN);

  localparam logic [ADDRESS_WRITE_IN:0] c_DEPTH    = c_PW'(c_DEPTH_INT);
  localparam logic [ADDRESS_WRITE_IN:0] c_AF_LEVEL = c_PW'(AF_LEVEL);

  localparam bit c_RATIO_OK = (ADDRESS_WRITE_OUT >= ADDRESS_WRITE_IN)
                            ? (DATA_WRITE_IN  == (DATA_WRITE_OUT << c_SHIFT))
                            : (DATA_WRITE_OUT == (DATA_WRITE_IN  << c_SHIFT));

  if (!c_RATIO_OK || (AF_LEVEL < 1) || (AF_LEVEL > c_DEPTH_INT)) begin : g_param_check
    $error("async_fifo_wr_ctrl: inconsistent width ratio or AF_LEVEL out of range");
  end

  logic [ADDRESS_WRITE_IN:0]   r_wr_bin;
  logic [ADDRESS_WRITE_IN:0]   r_wr_gray;
  logic                        r_wr_en;
  logic [ADDRESS_WRITE_IN-1:0] r_addr_wr;
  logic [DATA_WRITE_IN-1:0]    r_d;
  logic                        r_full;
  logic                        r_afull;
  logic [ADDRESS_WRITE_IN:0]   r_count;
  logic                        r_overflow;

  logic                        w_accept;
  logic [ADDRESS_WRITE_IN:0]   w_wr_bin_next;
  logic [ADDRESS_WRITE_IN:0]   w_wr_gray_next;
  logic [ADDRESS_WRITE_OUT:0]  w_rd_gray_sync;
  logic [ADDRESS_WRITE_OUT:0]  w_rd_bin;
  logic [ADDRESS_WRITE_IN:0]   w_rd_al;
  logic [ADDRESS_WRITE_IN:0]   w_lvl_next;

  gray_ptr_sync2 #(
    .WIDTH (c_RW)
  ) u_rd_ptr_sync (
    .CLK (CLK),
    .RST (RST),
    .D   (RD_PTR_GRAY),
    .Q   (w_rd_gray_sync)
  );

  assign w_rd_bin = c_RW'(gray2bin(ptr_word_t'(w_rd_gray_sync), c_RW));

  // Narrower read words: dropping the low bits floors the read position, so a
  // partially consumed write word still counts as occupied.
  if (ADDRESS_WRITE_OUT > ADDRESS_WRITE_IN) begin : g_align_shr
    assign w_rd_al = c_PW'(w_rd_bin >> c_SHIFT);
  end else if (ADDRESS_WRITE_OUT < ADDRESS_WRITE_IN) begin : g_align_shl
    assign w_rd_al = c_PW'(w_rd_bin) << c_SHIFT;
  end else begin : g_align_eq
    assign w_rd_al = c_PW'(w_rd_bin);
  end

  assign w_accept       = WR_REQ & ~r_full;
  assign w_wr_bin_next  = r_wr_bin + {{ADDRESS_WRITE_IN{1'b0}}, w_accept};
  assign w_wr_gray_next = c_PW'(bin2gray(ptr_word_t'(w_wr_bin_next), c_PW));
  // Modular subtraction; the extra MSB separates full from empty across wrap.
  assign w_lvl_next     = w_wr_bin_next - w_rd_al;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_bin   <= '0;
      r_wr_gray  <= '0;
      r_wr_en    <= 1'b0;
      r_addr_wr  <= '0;
      r_d        <= '0;
      r_full     <= 1'b0;
      r_afull    <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_addr_wr <= r_wr_bin[ADDRESS_WRITE_IN-1:0];
        r_d       <= DIN;
      end
      r_wr_bin  <= w_wr_bin_next;
      r_wr_gray <= w_wr_gray_next;
      r_full    <= (w_lvl_next == c_DEPTH);
      r_afull   <= (w_lvl_next >= c_AF_LEVEL);
      r_count   <= w_lvl_next;
      if (WR_REQ && r_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign WR_EN       = r_wr_en;
  assign ADDR_WR     = r_addr_wr;
  assign D           = r_d;
  assign WR_PTR_GRAY = r_wr_gray;
  assign FULL        = r_full;
  assign ALMOST_FULL = r_afull;
  assign WR_COUNT    = r_count;
  assign OVERFLOW    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_async_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_async_fifo_wr_ctrl
// Description : Directed self-checking bench for async_fifo_wr_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_async_fifo_wr_ctrl;

  logic        CLK;
  logic        RST;
  logic        WR_REQ;
  logic [63:0] DIN;
  logic [7:0]  RD_PTR_GRAY;
  logic        WR_EN;
  logic [4:0]  ADDR_WR;
  logic [63:0] D;
  logic [5:0]  WR_PTR_GRAY;
  logic        FULL;
  logic        ALMOST_FULL;
  logic [5:0]  WR_COUNT;
  logic        OVERFLOW;

  int n_tot  = 0;
  int n_pass = 0;

  async_fifo_wr_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .WR_REQ      (WR_REQ),
    .DIN         (DIN),
    .RD_PTR_GRAY (RD_PTR_GRAY),
    .WR_EN       (WR_EN),
    .ADDR_WR     (ADDR_WR),
    .D           (D),
    .WR_PTR_GRAY (WR_PTR_GRAY),
    .FULL        (FULL),
    .ALMOST_FULL (ALMOST_FULL),
    .WR_COUNT    (WR_COUNT),
    .OVERFLOW    (OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [5:0] gray6(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [63:0] pat(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 ^ 32'(i)};
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1; WR_REQ = 1'b0; DIN = '0; RD_PTR_GRAY = '0;
    tick(); tick();
    n_tot++;
    if ({WR_EN, ADDR_WR, D, WR_PTR_GRAY, FULL, ALMOST_FULL, WR_COUNT, OVERFLOW} !== 85'd0)
      $display("FAIL reset_state: got %h want 0",
               {WR_EN, ADDR_WR, D, WR_PTR_GRAY, FULL, ALMOST_FULL, WR_COUNT, OVERFLOW});
    else n_pass++;
    RST = 1'b0;
    tick();
    n_tot++;
    if ({WR_EN, WR_PTR_GRAY, FULL, WR_COUNT, OVERFLOW} !== 15'd0)
      $display("FAIL idle_after_reset: got %h want 0", {WR_EN, WR_PTR_GRAY, FULL, WR_COUNT, OVERFLOW});
    else n_pass++;
  endtask

  task automatic test_fill;
    WR_REQ = 1'b1;
    for (int i = 0; i < 33; i++) begin
      DIN = pat(i);
      tick();
      if (i < 32) begin
        n_tot++;
        if ({WR_EN, ADDR_WR, D} !== {1'b1, 5'(i), pat(i)})
          $display("FAIL fill_write[%0d]: got %h want %h", i, {WR_EN, ADDR_WR, D}, {1'b1, 5'(i), pat(i)});
        else n_pass++;
        n_tot++;
        if ({FULL, ALMOST_FULL, WR_COUNT, OVERFLOW} !== {i == 31, (i + 1) >= 28, 6'(i + 1), 1'b0})
          $display("FAIL fill_status[%0d]: got %h want %h", i, {FULL, ALMOST_FULL, WR_COUNT, OVERFLOW},
                   {i == 31, (i + 1) >= 28, 6'(i + 1), 1'b0});
        else n_pass++;
        n_tot++;
        if (WR_PTR_GRAY !== gray6(6'(i + 1)))
          $display("FAIL fill_gray[%0d]: got %h want %h", i, WR_PTR_GRAY, gray6(6'(i + 1)));
        else n_pass++;
      end else begin
        n_tot++;
        if ({WR_EN, ADDR_WR, D} !== {1'b0, 5'd31, pat(31)})
          $display("FAIL overflow_drop: got %h want %h", {WR_EN, ADDR_WR, D}, {1'b0, 5'd31, pat(31)});
        else n_pass++;
        n_tot++;
        if ({FULL, ALMOST_FULL, WR_COUNT, OVERFLOW, WR_PTR_GRAY} !== {1'b1, 1'b1, 6'd32, 1'b1, gray6(6'd32)})
          $display("FAIL overflow_status: got %h want %h", {FULL, ALMOST_FULL, WR_COUNT, OVERFLOW, WR_PTR_GRAY},
                   {1'b1, 1'b1, 6'd32, 1'b1, gray6(6'd32)});
        else n_pass++;
      end
    end
    WR_REQ = 1'b0;
  endtask

  task automatic test_read_floor;
    RD_PTR_GRAY = 8'h02;
    tick(); tick(); tick(); tick();
    n_tot++;
    if ({WR_EN, FULL, ALMOST_FULL, WR_COUNT} !== {1'b0, 1'b1, 1'b1, 6'd32})
      $display("FAIL read_floor: got %h want %h", {WR_EN, FULL, ALMOST_FULL, WR_COUNT}, {1'b0, 1'b1, 1'b1, 6'd32});
    else n_pass++;
  endtask

  task automatic test_full_release;
    RD_PTR_GRAY = 8'h06;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_tot++;
      if (FULL !== (k < 3))
        $display("FAIL full_release_edge%0d: got %b want %b", k, FULL, (k < 3));
      else n_pass++;
    end
    n_tot++;
    if ({ALMOST_FULL, WR_COUNT} !== {1'b1, 6'd31})
      $display("FAIL full_release_level: got %h want %h", {ALMOST_FULL, WR_COUNT}, {1'b1, 6'd31});
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    WR_REQ = 1'b1;
    DIN = pat(100);
    tick();
    n_tot++;
    if ({WR_EN, ADDR_WR, D, FULL, WR_COUNT, WR_PTR_GRAY} !== {1'b1, 5'd0, pat(100), 1'b1, 6'd32, gray6(6'd33)})
      $display("FAIL refill_write: got %h want %h", {WR_EN, ADDR_WR, D, FULL, WR_COUNT, WR_PTR_GRAY},
               {1'b1, 5'd0, pat(100), 1'b1, 6'd32, gray6(6'd33)});
    else n_pass++;
    RD_PTR_GRAY = 8'h0C;
    DIN = pat(101);
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_tot++;
      if ({WR_EN, FULL} !== {1'b0, k < 3})
        $display("FAIL held_req_edge%0d: got %b want %b", k, {WR_EN, FULL}, {1'b0, k < 3});
      else n_pass++;
    end
    tick();
    n_tot++;
    if ({WR_EN, ADDR_WR, D, FULL, WR_COUNT} !== {1'b1, 5'd1, pat(101), 1'b1, 6'd32})
      $display("FAIL held_req_accept: got %h want %h", {WR_EN, ADDR_WR, D, FULL, WR_COUNT},
               {1'b1, 5'd1, pat(101), 1'b1, 6'd32});
    else n_pass++;
    WR_REQ = 1'b0;
  endtask

  task automatic test_wrap;
    logic [5:0] prev_gray;
    RD_PTR_GRAY = 8'hC0;
    tick(); tick(); tick();
    n_tot++;
    if ({FULL, ALMOST_FULL, WR_COUNT} !== {1'b0, 1'b0, 6'd2})
      $display("FAIL wrap_drain: got %h want %h", {FULL, ALMOST_FULL, WR_COUNT}, {1'b0, 1'b0, 6'd2});
    else n_pass++;
    prev_gray = WR_PTR_GRAY;
    WR_REQ = 1'b1;
    for (int j = 0; j < 30; j++) begin
      DIN = pat(200 + j);
      tick();
      n_tot++;
      if ({WR_EN, ADDR_WR, WR_PTR_GRAY} !== {1'b1, 5'(2 + j), gray6(6'(35 + j))})
        $display("FAIL wrap_write[%0d]: got %h want %h", j, {WR_EN, ADDR_WR, WR_PTR_GRAY},
                 {1'b1, 5'(2 + j), gray6(6'(35 + j))});
      else n_pass++;
      n_tot++;
      if ($countones(WR_PTR_GRAY ^ prev_gray) != 1)
        $display("FAIL wrap_gray_step[%0d]: got %h after %h want one bit change", j, WR_PTR_GRAY, prev_gray);
      else n_pass++;
      prev_gray = WR_PTR_GRAY;
    end
    WR_REQ = 1'b0;
    n_tot++;
    if ({FULL, WR_COUNT, WR_PTR_GRAY} !== {1'b1, 6'd32, 6'd0})
      $display("FAIL wrap_full: got %h want %h", {FULL, WR_COUNT, WR_PTR_GRAY}, {1'b1, 6'd32, 6'd0});
    else n_pass++;
    RD_PTR_GRAY = 8'h00;
    tick(); tick(); tick();
    n_tot++;
    if ({FULL, ALMOST_FULL, WR_COUNT, WR_PTR_GRAY} !== {1'b0, 1'b0, 6'd0, 6'd0})
      $display("FAIL wrap_empty: got %h want %h", {FULL, ALMOST_FULL, WR_COUNT, WR_PTR_GRAY},
               {1'b0, 1'b0, 6'd0, 6'd0});
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    WR_REQ = 1'b1;
    for (int i = 0; i < 10; i++) begin
      DIN = pat(300 + i);
      tick();
    end
    n_tot++;
    if ({WR_COUNT, ADDR_WR, OVERFLOW} !== {6'd10, 5'd9, 1'b1})
      $display("FAIL mid_burst_level: got %h want %h", {WR_COUNT, ADDR_WR, OVERFLOW}, {6'd10, 5'd9, 1'b1});
    else n_pass++;
    RST = 1'b1;
    DIN = pat(400);
    tick();
    n_tot++;
    if ({WR_EN, ADDR_WR, D, WR_PTR_GRAY, FULL, ALMOST_FULL, WR_COUNT, OVERFLOW} !== 85'd0)
      $display("FAIL mid_reset_clear: got %h want 0",
               {WR_EN, ADDR_WR, D, WR_PTR_GRAY, FULL, ALMOST_FULL, WR_COUNT, OVERFLOW});
    else n_pass++;
    RST = 1'b0;
    tick();
    n_tot++;
    if ({WR_EN, ADDR_WR, D, WR_COUNT, WR_PTR_GRAY} !== {1'b1, 5'd0, pat(400), 6'd1, 6'd1})
      $display("FAIL restart_write: got %h want %h", {WR_EN, ADDR_WR, D, WR_COUNT, WR_PTR_GRAY},
               {1'b1, 5'd0, pat(400), 6'd1, 6'd1});
    else n_pass++;
    WR_REQ = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_read_floor();
    test_full_release();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
